mont_mul_256: RTL and testbench

MONT_MUL_256 -- requirements
Module: mont_mul_256

---
 rtl/mont_mul_256_pkg.sv | 20 ++
 rtl/mont_mul_256_word_step.sv | 21 ++
 rtl/mont_mul_256.sv | 179 +++++++++++++++++
 tb/tb_mont_mul_256.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mont_mul_256_pkg.sv
// Shared definitions for the 256-bit word-serial Montgomery multiplier:
// word geometry, accumulator widths and the controller state encoding.
package mont_mul_256_pkg;

  localparam int MM_W     = 32;               // word width of b, u and n_inv
  localparam int MM_WORDS = 8;                // words of b consumed per product
  localparam int MM_OP_W  = 256;              // operand / modulus / result width
  localparam int MM_T_W   = 257;              // running value T, always < 2n
  localparam int MM_S_W   = 289;              // S = T + a*b_i, and S + u*n
  localparam int MM_P_W   = MM_OP_W + MM_W;   // 256x32 partial product width

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_RED  = 3'd2,
    ST_SUB  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/mont_mul_256_word_step.sv
// mont_word_step: combinational 256x32 multiply plus the Montgomery quotient
// digit u = (-lo * n_inv) mod 2^32. The top time-shares one instance: the
// multiplier forms a*b_i in MUL and u*n in RED.
module mont_word_step
  import mont_mul_256_pkg::*;
(
  input  logic [MM_OP_W-1:0] i_x,
  input  logic [MM_W-1:0]    i_y,
  input  logic [MM_W-1:0]    i_lo,
  input  logic [MM_W-1:0]    i_n_inv,
  output logic [MM_P_W-1:0]  o_prod,
  output logic [MM_W-1:0]    o_u
);

  // Full-width product; the 288-bit result never overflows.
  assign o_prod = MM_P_W'(i_x) * MM_P_W'(i_y);

  // Quotient digit: chosen so that lo + u*n0 == 0 mod 2^32.
  assign o_u = (MM_W'(0) - i_lo) * i_n_inv;

endmodule

// File: rtl/mont_mul_256.sv
// mont_mul_256: word-serial Montgomery product result = a*b*2^-256 mod n.
// Eight MUL/RED pairs consume b one 32-bit word at a time, then a single
// conditional subtraction brings T (< 2n) into [0, n).
//
// Handshake: a request is accepted on a rising edge where start && ready.
// ready is high only in IDLE; starts seen while busy are dropped, never queued.
// done pulses for one cycle when result is valid; result holds until the next
// accepted start or reset.
//
// Optional feature macro: MONT_INPUT_CHECK_EN. When defined, an accepted start
// with a >= n, b >= n or even n skips the computation, goes straight to DONE
// and raises err (sticky until the next accepted start or reset). When not
// defined, err is tied low and no input comparators exist.
module mont_mul_256
  import mont_mul_256_pkg::*;
#(
  parameter int WORDS = MM_WORDS,
  parameter int W     = MM_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  input  logic [MM_OP_W-1:0] a,
  input  logic [MM_OP_W-1:0] b,
  input  logic [MM_OP_W-1:0] n,
  input  logic [MM_W-1:0]    n_inv,
  output logic               done,
  output logic [MM_OP_W-1:0] result,
  output logic               err,
  output state_t             dbg_state
);

  localparam int                CNT_W    = $clog2(WORDS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WORDS - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [MM_OP_W-1:0]   r_a;
  logic [MM_OP_W-1:0]   r_b;
  logic [MM_OP_W-1:0]   r_n;
  logic [MM_W-1:0]      r_n_inv;
  logic [MM_S_W-1:0]    r_s;
  logic [MM_T_W-1:0]    r_t;
  logic [MM_OP_W-1:0]   r_result;

  logic [MM_W-1:0]      w_b_word;
  logic [MM_OP_W-1:0]   w_x;
  logic [MM_W-1:0]      w_y;
  logic [MM_P_W-1:0]    w_prod;
  logic [MM_W-1:0]      w_u;
  logic [MM_S_W-1:0]    w_s_next;
  logic [MM_S_W-1:0]    w_red_sum;
  logic [MM_T_W-1:0]    w_t_next;
  logic                 w_t_ge_n;
  logic [MM_OP_W-1:0]   w_sub_res;
  logic                 w_accept;

  assign w_accept = start && (r_state == ST_IDLE);

`ifdef MONT_INPUT_CHECK_EN
  logic r_err;
  logic w_in_bad;
  // Precondition check on the raw inputs at the moment of acceptance.
  assign w_in_bad = (a >= n) || (b >= n) || !n[0];
`endif

  // Current word of b selected by the iteration counter.
  assign w_b_word = r_b[r_cnt * W +: W];

  // One multiplier, shared: a*b_i during MUL, u*n during RED.
  assign w_x = (r_state == ST_RED) ? r_n : r_a;
  assign w_y = (r_state == ST_RED) ? w_u : w_b_word;

  mont_word_step u_step (
    .i_x     (w_x),
    .i_y     (w_y),
    .i_lo    (r_s[MM_W-1:0]),
    .i_n_inv (r_n_inv),
    .o_prod  (w_prod),
    .o_u     (w_u)
  );

  // S + u*n is exactly T_next * 2^32 with T_next < 2n, so 289 bits hold it.
  assign w_s_next  = MM_S_W'(r_t) + MM_S_W'(w_prod);
  assign w_red_sum = r_s + MM_S_W'(w_prod);
  assign w_t_next  = w_red_sum[MM_S_W-1:MM_W];

  // Final correction; low-256 arithmetic is exact because T - n < n < 2^256.
  assign w_t_ge_n  = (r_t >= MM_T_W'(r_n));
  assign w_sub_res = w_t_ge_n ? (r_t[MM_OP_W-1:0] - r_n) : r_t[MM_OP_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: IDLE -> (MUL -> RED) x8 -> SUB -> DONE -> IDLE.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
`ifdef MONT_INPUT_CHECK_EN
          w_state_next = w_in_bad ? ST_DONE : ST_MUL;
`else
          w_state_next = ST_MUL;
`endif
        end
      end
      ST_MUL:  w_state_next = ST_RED;
      ST_RED:  w_state_next = (r_cnt == LAST_CNT) ? ST_SUB : ST_MUL;
      ST_SUB:  w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath registers: operand capture, S/T accumulation, counter, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_n      <= '0;
      r_n_inv  <= '0;
      r_s      <= '0;
      r_t      <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_n     <= n;
            r_n_inv <= n_inv;
            r_t     <= '0;
            r_cnt   <= '0;
          end
        end
        ST_MUL: r_s <= w_s_next;
        ST_RED: begin
          r_t <= w_t_next;
          if (r_cnt != LAST_CNT) r_cnt <= r_cnt + 1'b1;
        end
        ST_SUB:  r_result <= w_sub_res;
        default: ;
      endcase
    end
  end

`ifdef MONT_INPUT_CHECK_EN
  // Sticky input-check flag, refreshed on every accepted start.
  always_ff @(posedge clk) begin
    if (rst)           r_err <= 1'b0;
    else if (w_accept) r_err <= w_in_bad;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // The quotient digit must cancel the low word; a residue means n_inv or n is wrong.
  always_ff @(posedge clk) begin
    if (!rst && r_state == ST_RED) begin
      assert (w_red_sum[MM_W-1:0] == '0)
        else $error("mont_mul_256: nonzero low word after reduction");
    end
  end

  assign ready     = (r_state == ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign result    = r_result;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mont_mul_256.sv
// Self-checking bench for mont_mul_256. Reference results come from a
// bit-serial halving model of a*b*2^-256 mod n using plain wide arithmetic.
// Build with MONT_INPUT_CHECK_EN defined to also exercise the input check.
module tb_mont_mul_256;
  import mont_mul_256_pkg::*;

  logic         clk;
  logic         rst;
  logic         start;
  logic         ready;
  logic [255:0] a;
  logic [255:0] b;
  logic [255:0] n;
  logic [31:0]  n_inv;
  logic         done;
  logic [255:0] result;
  logic         err;
  state_t       dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [255:0] last_res;
  logic [255:0] p25519;

  mont_mul_256 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ready     (ready),
    .a         (a),
    .b         (b),
    .n         (n),
    .n_inv     (n_inv),
    .done      (done),
    .result    (result),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required summary before 200000");
    $fatal(1, "watchdog");
  end

  // Reference model helpers
  function automatic logic [31:0] inv32(input logic [31:0] n0);
    logic [31:0] x;
    x = n0;
    repeat (5) x = x * (32'd2 - n0 * x);
    return x;
  endfunction

  function automatic logic [255:0] mont_ref(input logic [255:0] ra, input logic [255:0] rb,
                                            input logic [255:0] rn);
    logic [511:0] x;
    logic [256:0] y;
    x = 512'(ra) * 512'(rb);
    x = x % 512'(rn);
    y = x[256:0];
    // Dividing by 2 mod n, 256 times, is multiplying by 2^-256 mod n.
    for (int i = 0; i < 256; i++) y = y[0] ? ((y + 257'(rn)) >> 1) : (y >> 1);
    return y[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Checkers
  task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Driver: one operation from an IDLE cycle, checks latency, result, err, hold.
  task automatic run_op(input logic [255:0] xa, input logic [255:0] xb, input logic [255:0] xn,
                        input int exp_lat, input logic exp_err, input logic [255:0] exp_res,
                        input string tag);
    int cyc;
    a = xa; b = xb; n = xn; n_inv = inv32(xn[31:0]); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble operands after acceptance; they must not matter.
    a = ~xa; b = ~xb; n = ~xn; n_inv = ~n_inv;
    check_bit({tag, " busy"}, ready, 1'b0);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_int({tag, " latency"}, cyc, exp_lat);
    check_vec({tag, " result"}, result, exp_res);
    check_bit({tag, " err"}, err, exp_err);
    @(posedge clk); #1;
    check_bit({tag, " pulse"}, done, 1'b0);
    check_bit({tag, " idle"}, ready, 1'b1);
    check_vec({tag, " hold"}, result, exp_res);
    check_bit({tag, " err hold"}, err, exp_err);
    last_res = exp_res;
  endtask

  // Directed sequence
  initial begin
    logic [255:0] ra, rb, rn, a1, a2, exp1, exp2;
    int cyc, ndone;
    int dcyc[3];
    logic [255:0] dres[3];

    p25519 = (256'd1 << 255) - 256'd19;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; n = '0; n_inv = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_bit("reset ready", ready, 1'b1);
    check_bit("reset done", done, 1'b0);
    check_bit("reset err", err, 1'b0);
    check_vec("reset result", result, '0);
    check_int("reset state", int'(dbg_state), int'(ST_IDLE));

    // a = 2^256 mod n, so the product is b itself.
    run_op(256'd38, 256'd5, p25519, 18, 1'b0, 256'd5, "r5");

    // Reset mid-operation: start at k, rst at k+7.
    a = 256'd7; b = 256'd9; n = p25519; n_inv = inv32(p25519[31:0]); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i < 7; i++) begin
      if (done === 1'b1) ndone++;
      @(posedge clk); #1;
    end
    if (done === 1'b1) ndone++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_int("abort no done", ndone, 0);
    check_bit("abort ready", ready, 1'b1);
    check_bit("abort done", done, 1'b0);
    check_vec("abort result", result, '0);
    @(posedge clk); #1;
    run_op(256'd7, 256'd9, p25519, 18, 1'b0, mont_ref(256'd7, 256'd9, p25519), "after abort");

    run_op(256'd0, p25519 - 256'd1, p25519, 18, 1'b0, 256'd0, "zero");
    run_op(p25519 - 256'd1, p25519 - 256'd1, p25519, 18, 1'b0,
           mont_ref(p25519 - 256'd1, p25519 - 256'd1, p25519), "nm1sq");

    // Random odd moduli and reduced operands.
    for (int t = 0; t < 6; t++) begin
      rn = rand256(); rn[255] = 1'b1; rn[0] = 1'b1;
      ra = rand256() % rn;
      rb = rand256() % rn;
      run_op(ra, rb, rn, 18, 1'b0, mont_ref(ra, rb, rn), "rand");
    end
    rn = rand256(); rn[255] = 1'b1; rn[0] = 1'b1;
    run_op(rn - 256'd1, rn - 256'd1, rn, 18, 1'b0,
           mont_ref(rn - 256'd1, rn - 256'd1, rn), "rand nm1");

    // start held high across three operations; a changes at k+5.
    a1 = rand256() % p25519;
    a2 = rand256() % p25519;
    rb = rand256() % p25519;
    exp1 = mont_ref(a1, rb, p25519);
    exp2 = mont_ref(a2, rb, p25519);
    a = a1; b = rb; n = p25519; n_inv = inv32(p25519[31:0]); start = 1'b1;
    dcyc[0] = -1; dcyc[1] = -1; dcyc[2] = -1;
    dres[0] = '0; dres[1] = '0; dres[2] = '0;
    @(posedge clk); #1;
    cyc = 1; ndone = 0;
    while (ndone < 3 && cyc < 80) begin
      if (cyc == 5) a = a2;
      if (done === 1'b1) begin
        dcyc[ndone] = cyc;
        dres[ndone] = result;
        ndone++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check_int("stream count", ndone, 3);
    check_int("stream done0", dcyc[0], 18);
    check_int("stream done1", dcyc[1], 37);
    check_int("stream done2", dcyc[2], 56);
    check_vec("stream res0", dres[0], exp1);
    check_vec("stream res1", dres[1], exp2);
    check_vec("stream res2", dres[2], exp2);
    last_res = exp2;
    @(posedge clk); #1;
    check_bit("stream idle", ready, 1'b1);

`ifdef MONT_INPUT_CHECK_EN
    // Even modulus is rejected at once; result keeps the previous value.
    run_op(256'd5, 256'd5, p25519 + 256'd1, 1, 1'b1, last_res, "even n");
    run_op(256'd38, 256'd11, p25519, 18, 1'b0, 256'd11, "err clear");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
